fifo_pack_reader: RTL and testbench

//  Read-side consumer for the push/pop FiFo: pops narrow words from the FIFO head
//  (async-read dout/empty/pop interface) and packs RATIO of them LSB-first into one wide word.

---
 rtl/fifo_pack_reader_pkg.sv | 24 ++
 rtl/fifo_pack_reader_if.sv | 32 +++
 rtl/fifo_pack_reader_out_slot.sv | 45 ++++
 rtl/fifo_pack_reader.sv | 121 ++++++++++++
 tb/tb_fifo_pack_reader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pack_reader_pkg.sv
// Shared definitions for the FIFO pack reader: default geometry and a width helper.
// Imported by the interface, the output slot and the top level.
package fifo_pack_reader_pkg;

    localparam int unsigned FPR_DATA_WIDTH = 32'd2;
    localparam int unsigned FPR_RATIO      = 32'd4;

    // Number of bits needed to index 'value' distinct states.
    function automatic int unsigned fpr_clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 32'd1;
        r = 32'd0;
        while (v > 32'd0) begin
            r = r + 32'd1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int unsigned FPR_OUT_WIDTH = FPR_DATA_WIDTH * FPR_RATIO;
    localparam int unsigned FPR_CNT_WIDTH = fpr_clog2(FPR_RATIO + 32'd1);

endpackage

// File: rtl/fifo_pack_reader_if.sv
// Bundle of the narrow FIFO read port, the flush request and the wide output stream.
// The slave modport is the packer; the master modport is the FIFO/downstream side.
interface fifo_pack_reader_if
    import fifo_pack_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FPR_DATA_WIDTH,
    parameter int unsigned RATIO      = FPR_RATIO
);
    localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int unsigned CNT_WIDTH = fpr_clog2(RATIO + 32'd1);

    logic [DATA_WIDTH-1:0] io_fifo_dout;
    logic                  io_fifo_empty;
    logic                  io_fifo_pop;
    logic                  io_flush;
    logic [OUT_WIDTH-1:0]  io_out_data;
    logic [CNT_WIDTH-1:0]  io_out_count;
    logic                  io_out_valid;
    logic                  io_out_ready;
    logic                  io_busy;

    modport master (
        output io_fifo_dout, io_fifo_empty, io_flush, io_out_ready,
        input  io_fifo_pop, io_out_data, io_out_count, io_out_valid, io_busy
    );

    modport slave (
        input  io_fifo_dout, io_fifo_empty, io_flush, io_out_ready,
        output io_fifo_pop, io_out_data, io_out_count, io_out_valid, io_busy
    );

endinterface

// File: rtl/fifo_pack_reader_out_slot.sv
// Single-entry valid/ready holding register for packed words.
// A new word may load on the same edge the current one drains.
module fifo_out_slot #(
    parameter int unsigned OUT_WIDTH = 32'd8,
    parameter int unsigned CNT_WIDTH = 32'd3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] load_data,
    input  logic [CNT_WIDTH-1:0] load_count,
    input  logic                 ready,
    output logic [OUT_WIDTH-1:0] data,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 valid,
    output logic                 slot_free
);

    logic [OUT_WIDTH-1:0] data_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 valid_r;

    // Slot register: load wins over drain; data/count stay put until replaced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r  <= {OUT_WIDTH{1'b0}};
            count_r <= {CNT_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            count_r <= load_count;
            valid_r <= 1'b1;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign slot_free = ~valid_r | ready;
    assign data      = data_r;
    assign count     = count_r;
    assign valid     = valid_r;

endmodule

// File: rtl/fifo_pack_reader.sv
// Pops narrow FIFO words and packs RATIO of them LSB-first into a wide word,
// with a flush path that emits a partial word and its word count.
module fifo_pack_reader
    import fifo_pack_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FPR_DATA_WIDTH,
    parameter int unsigned RATIO      = FPR_RATIO
) (
    input  logic              clk,
    input  logic              reset,
    fifo_pack_reader_if.slave bus
);

    localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int unsigned CNT_WIDTH = fpr_clog2(RATIO + 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(RATIO);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 32'd1);

    logic [OUT_WIDTH-1:0] pack_r;
    logic [OUT_WIDTH-1:0] pack_nxt_s;
    logic [OUT_WIDTH-1:0] pack_pop_s;
    logic [OUT_WIDTH-1:0] load_data_s;
    logic [CNT_WIDTH-1:0] pack_cnt_r;
    logic [CNT_WIDTH-1:0] pack_cnt_nxt_s;
    logic [CNT_WIDTH-1:0] load_count_s;
    logic                 flush_pend_r;
    logic                 flush_pend_nxt_s;
    logic                 pop_s;
    logic                 complete_s;
    logic                 flush_set_s;
    logic                 load_s;
    logic                 slot_free_s;
    logic                 out_valid_s;

    // Pop never looks at io_out_ready; a full pack simply parks at RATIO.
    assign pop_s       = reset & ~bus.io_fifo_empty & (pack_cnt_r != CNT_FULL) & ~flush_pend_r;
    assign complete_s  = pop_s & (pack_cnt_r == CNT_LAST);
    assign flush_set_s = bus.io_flush & (pack_cnt_r != CNT_ZERO) & ~complete_s;

    // Pack register image with the popped word written into its slot.
    always_comb begin
        pack_pop_s = pack_r;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (pop_s && (pack_cnt_r == CNT_WIDTH'(i))) begin
                pack_pop_s[i*DATA_WIDTH +: DATA_WIDTH] = bus.io_fifo_dout;
            end else begin
                pack_pop_s[i*DATA_WIDTH +: DATA_WIDTH] = pack_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state for the pack counter, pack register, flush request and slot load.
    always_comb begin
        pack_nxt_s       = pack_r;
        pack_cnt_nxt_s   = pack_cnt_r;
        flush_pend_nxt_s = flush_pend_r | flush_set_s;
        load_s           = 1'b0;
        load_data_s      = pack_r;
        load_count_s     = pack_cnt_r;
        if ((flush_pend_r || (pack_cnt_r == CNT_FULL)) && slot_free_s) begin
            // Held full word or pending partial word leaves as is; upper bits are already zero.
            load_s           = 1'b1;
            pack_nxt_s       = {OUT_WIDTH{1'b0}};
            pack_cnt_nxt_s   = CNT_ZERO;
            flush_pend_nxt_s = 1'b0;
        end else if (complete_s) begin
            if (slot_free_s) begin
                load_s         = 1'b1;
                load_data_s    = pack_pop_s;
                load_count_s   = CNT_FULL;
                pack_nxt_s     = {OUT_WIDTH{1'b0}};
                pack_cnt_nxt_s = CNT_ZERO;
            end else begin
                pack_nxt_s     = pack_pop_s;
                pack_cnt_nxt_s = CNT_FULL;
            end
        end else if (pop_s) begin
            pack_nxt_s     = pack_pop_s;
            pack_cnt_nxt_s = pack_cnt_r + CNT_ONE;
        end else begin
            pack_nxt_s     = pack_r;
            pack_cnt_nxt_s = pack_cnt_r;
        end
    end

    // Packing state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pack_r       <= {OUT_WIDTH{1'b0}};
            pack_cnt_r   <= CNT_ZERO;
            flush_pend_r <= 1'b0;
        end else begin
            pack_r       <= pack_nxt_s;
            pack_cnt_r   <= pack_cnt_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
        end
    end

    fifo_out_slot #(
        .OUT_WIDTH (OUT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_data  (load_data_s),
        .load_count (load_count_s),
        .ready      (bus.io_out_ready),
        .data       (bus.io_out_data),
        .count      (bus.io_out_count),
        .valid      (out_valid_s),
        .slot_free  (slot_free_s)
    );

    assign bus.io_out_valid = out_valid_s;
    assign bus.io_fifo_pop  = pop_s;
    assign bus.io_busy      = (pack_cnt_r != CNT_ZERO) | out_valid_s | flush_pend_r;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader: a queue-based FIFO feeds the packer, a queue-of-words model
// predicts outputs every cycle, and directed scenarios pin the model with literal words.
module tb_fifo_pack_reader;
    import fifo_pack_reader_pkg::*;

    localparam int DW = 2;
    localparam int R  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_pack_reader_if bus ();

    fifo_pack_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend[$];
    bit            mfp;
    bit            mv;
    logic [7:0]    mdata;
    logic [2:0]    mcnt;

    logic [7:0] acc_data[$];
    logic [2:0] acc_cnt[$];
    int         valid_cycles;
    int         pop_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pack_words();
        logic [7:0] w;
        w = 8'h00;
        for (int i = 0; i < pend.size(); i++) w[i*DW +: DW] = pend[i];
        return w;
    endfunction

    task automatic model_reset();
        pend.delete();
        mfp   = 1'b0;
        mv    = 1'b0;
        mdata = 8'h00;
        mcnt  = 3'd0;
    endtask

    // One clock: check registered outputs, apply inputs, check pop, advance the model.
    task automatic step(input logic fl, input logic rd);
        bit mpop;
        bit sf;
        bit emit;
        int osz;
        @(negedge clk);
        chk("out_valid", {31'd0, bus.io_out_valid}, {31'd0, mv});
        if (mv) begin
            chk("out_data", {24'd0, bus.io_out_data}, {24'd0, mdata});
            chk("out_count", {29'd0, bus.io_out_count}, {29'd0, mcnt});
        end
        chk("busy", {31'd0, bus.io_busy}, {31'd0, ((pend.size() != 0) || mv || mfp)});
        if (bus.io_out_valid === 1'b1) valid_cycles++;
        bus.io_flush      = fl;
        bus.io_out_ready  = rd;
        bus.io_fifo_empty = (fq.size() == 0);
        bus.io_fifo_dout  = (fq.size() != 0) ? fq[0] : 2'd0;
        #1;
        osz  = pend.size();
        sf   = !mv || rd;
        mpop = (fq.size() != 0) && (osz != R) && !mfp;
        chk("fifo_pop", {31'd0, bus.io_fifo_pop}, {31'd0, mpop});
        if (bus.io_fifo_pop === 1'b1) pop_seen++;
        if (bus.io_out_valid === 1'b1 && rd) begin
            acc_data.push_back(bus.io_out_data);
            acc_cnt.push_back(bus.io_out_count);
        end
        emit = 1'b0;
        if ((mfp || osz == R) && sf) begin
            emit = 1'b1;
        end else if (mpop) begin
            pend.push_back(fq.pop_front());
            if (pend.size() == R && sf) emit = 1'b1;
        end
        if (emit) begin
            mdata = pack_words();
            mcnt  = 3'(pend.size());
            pend.delete();
            mfp = 1'b0;
            mv  = 1'b1;
        end else begin
            mfp = mfp || (fl && osz != 0 && !(mpop && osz == R - 1));
            if (mv && rd) mv = 1'b0;
        end
    endtask

    task automatic clear_acc();
        acc_data.delete();
        acc_cnt.delete();
        valid_cycles = 0;
        pop_seen     = 0;
    endtask

    initial begin
        bus.io_fifo_dout  = 2'd1;
        bus.io_fifo_empty = 1'b0;
        bus.io_flush      = 1'b0;
        bus.io_out_ready  = 1'b0;
        model_reset();
        clear_acc();

        // Reset state, with a non-empty FIFO to show pop is held off.
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.io_out_data}, 32'd0);
        chk("rst_count", {29'd0, bus.io_out_count}, 32'd0);
        chk("rst_pop", {31'd0, bus.io_fifo_pop}, 32'd0);
        chk("rst_busy", {31'd0, bus.io_busy}, 32'd0);
        bus.io_fifo_empty = 1'b1;
        reset = 1'b1;

        // Four pops, ready high: one word E4, count 4, valid for one cycle.
        clear_acc();
        for (int i = 0; i < 4; i++) fq.push_back(2'(i));
        repeat (8) step(1'b0, 1'b1);
        chk("s1_words", acc_data.size(), 32'd1);
        if (acc_data.size() >= 1) begin
            chk("s1_data", {24'd0, acc_data[0]}, 32'hE4);
            chk("s1_count", {29'd0, acc_cnt[0]}, 32'd4);
        end
        chk("s1_valid_cycles", valid_cycles, 32'd1);

        // Backpressure: second word parks in the packer, then both drain back-to-back.
        clear_acc();
        begin
            logic [1:0] seq [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
            for (int i = 0; i < 8; i++) fq.push_back(seq[i]);
        end
        repeat (12) step(1'b0, 1'b0);
        chk("s2_pops", pop_seen, 32'd8);
        chk("s2_held_valid", {31'd0, bus.io_out_valid}, 32'd1);
        chk("s2_held_data", {24'd0, bus.io_out_data}, 32'hE4);
        repeat (3) step(1'b0, 1'b1);
        chk("s2_words", acc_data.size(), 32'd2);
        if (acc_data.size() >= 2) begin
            chk("s2_first", {24'd0, acc_data[0]}, 32'hE4);
            chk("s2_second", {24'd0, acc_data[1]}, 32'h1B);
        end
        chk("s2_busy_low", {31'd0, bus.io_busy}, 32'd0);

        // Partial flush 3,1 -> 07/count 2; flush of an empty pack emits nothing.
        clear_acc();
        fq.push_back(2'd3);
        fq.push_back(2'd1);
        repeat (4) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        chk("s3_words", acc_data.size(), 32'd1);
        if (acc_data.size() >= 1) begin
            chk("s3_data", {24'd0, acc_data[0]}, 32'h07);
            chk("s3_count", {29'd0, acc_cnt[0]}, 32'd2);
        end

        // Flush together with the completing pop: a single full word only.
        clear_acc();
        for (int i = 0; i < 4; i++) fq.push_back(2'(i));
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);
        chk("s4_words", acc_data.size(), 32'd1);
        if (acc_data.size() >= 1) begin
            chk("s4_data", {24'd0, acc_data[0]}, 32'hE4);
            chk("s4_count", {29'd0, acc_cnt[0]}, 32'd4);
        end
        chk("s4_busy_low", {31'd0, bus.io_busy}, 32'd0);

        // Reset asserted mid-pack with a word waiting in the slot.
        clear_acc();
        begin
            logic [1:0] seq6 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
            for (int i = 0; i < 6; i++) fq.push_back(seq6[i]);
        end
        repeat (6) step(1'b0, 1'b0);
        @(posedge clk);
        #2;
        bus.io_fifo_empty = 1'b0;
        bus.io_fifo_dout  = 2'd3;
        chk("s5_valid_before", {31'd0, bus.io_out_valid}, 32'd1);
        chk("s5_pop_before", {31'd0, bus.io_fifo_pop}, 32'd1);
        reset = 1'b0;
        #1;
        chk("s5_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("s5_data", {24'd0, bus.io_out_data}, 32'd0);
        chk("s5_count", {29'd0, bus.io_out_count}, 32'd0);
        chk("s5_pop", {31'd0, bus.io_fifo_pop}, 32'd0);
        model_reset();
        fq.delete();
        bus.io_fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // FIFO empty throughout: never a pop, never busy.
        clear_acc();
        repeat (20) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("s6_no_pop", pop_seen, 32'd0);
        chk("s6_not_busy", {31'd0, bus.io_busy}, 32'd0);

        // Randomized traffic against the model.
        clear_acc();
        repeat (3000) begin
            if ($urandom_range(0, 99) < 40) fq.push_back(2'($urandom_range(0, 3)));
            step(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 99) < 60));
        end
        repeat (60) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);
        chk("rand_drained", {31'd0, bus.io_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
